// File: rtl/iob_soc_opencryptolinux_mem_arb_if.sv
// Bus bundle for the two-master external-memory arbiter.
// Packed layouts (MSB to LSB):
//   req  = {avalid, addr, wdata, wstrb}
//   resp = {rdata, rvalid, ready}
// Signals:
//   m0_req_i / m0_resp_o : master 0 (instruction bus) request / response
//   m1_req_i / m1_resp_o : master 1 (data bus) request / response
//   s_req_o  / s_resp_i  : merged request to / response from external memory
// Modports:
//   slave  : the arbiter side (consumes master requests, drives memory request)
//   master : the environment side (masters and memory model)
interface iob_soc_opencryptolinux_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 2;

  logic [REQ_W-1:0]  m0_req_i;
  logic [RESP_W-1:0] m0_resp_o;
  logic [REQ_W-1:0]  m1_req_i;
  logic [RESP_W-1:0] m1_resp_o;
  logic [REQ_W-1:0]  s_req_o;
  logic [RESP_W-1:0] s_resp_i;

  modport slave (
    input  m0_req_i, m1_req_i, s_resp_i,
    output m0_resp_o, m1_resp_o, s_req_o
  );

  modport master (
    output m0_req_i, m1_req_i, s_resp_i,
    input  m0_resp_o, m1_resp_o, s_req_o
  );
endinterface

// File: rtl/iob_soc_opencryptolinux_mem_arb.sv
// Two-master IOb arbiter merging the instruction and data request streams
// into the single external-memory port. Round-robin priority, one master
// granted at a time, at most one outstanding read whose response is routed
// back to the master that issued it.
// Ports:
//   clk_i     : system clock
//   cke_i     : clock enable; registered state advances only when 1
//   rst_i     : synchronous active-high reset (honoured regardless of cke_i)
//   bus       : master/slave request and response bundle (slave modport)
//   state_dbg : current FSM state (0 IDLE, 1 BUSY, 2 RD_WAIT)
//
// Handshake: a request is accepted on a cycle where avalid=1 and ready=1.
// wstrb != 0 marks a write (complete at acceptance); wstrb == 0 marks a read
// (complete on the first later cycle with memory rvalid=1). Masters hold req
// stable until ready; nothing is buffered here.
module iob_soc_opencryptolinux_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                                clk_i,
  input  logic                                cke_i,
  input  logic                                rst_i,
  iob_soc_opencryptolinux_mem_arb_if.slave    bus,
  output logic [1:0]                          state_dbg
);
  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int RESP_W = DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t state, state_n;
  logic   owner, owner_n;
  logic   prio, prio_n;

  logic [REQ_W-1:0]  owner_req;
  logic              m0_avalid, m1_avalid, owner_avalid, owner_write;
  logic              s_ready, s_rvalid;
  logic [DATA_W-1:0] s_rdata;
  logic [REQ_W-1:0]  s_req;
  logic              m0_ready, m1_ready, m0_rvalid, m1_rvalid;

  assign m0_avalid    = bus.m0_req_i[REQ_W-1];
  assign m1_avalid    = bus.m1_req_i[REQ_W-1];
  assign owner_req    = owner ? bus.m1_req_i : bus.m0_req_i;
  assign owner_avalid = owner_req[REQ_W-1];
  assign owner_write  = |owner_req[STRB_W-1:0];

  assign s_ready  = bus.s_resp_i[0];
  assign s_rvalid = bus.s_resp_i[1];
  assign s_rdata  = bus.s_resp_i[RESP_W-1:2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
    end else if (cke_i) begin
      state <= state_n;
      owner <= owner_n;
      prio  <= prio_n;
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    prio_n    = prio;
    s_req     = '0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;

    case (state)
      IDLE: begin
        if (m0_avalid || m1_avalid) begin
          // Tie goes to prio; otherwise the lone requester wins.
          owner_n = (m0_avalid && m1_avalid) ? prio : m1_avalid;
          state_n = BUSY;
        end
      end
      BUSY: begin
        s_req = owner_req;
        if (owner) m1_ready = s_ready;
        else       m0_ready = s_ready;
        if (owner_avalid && s_ready) begin
          if (owner_write) begin
            state_n = IDLE;
            prio_n  = ~owner;
          end else begin
            state_n = RD_WAIT;
          end
        end else if (!owner_avalid) begin
          // Withdrawn request: give up the grant without touching priority.
          state_n = IDLE;
        end
      end
      RD_WAIT: begin
        if (owner) m1_rvalid = s_rvalid;
        else       m0_rvalid = s_rvalid;
        if (s_rvalid) begin
          state_n = IDLE;
          prio_n  = ~owner;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Keep the ports quiet while reset is held, whatever the stale state.
    if (rst_i) begin
      s_req     = '0;
      m0_ready  = 1'b0;
      m1_ready  = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
    end
  end

  // rdata is broadcast; only rvalid and ready are steered.
  assign bus.s_req_o   = s_req;
  assign bus.m0_resp_o = {s_rdata, m0_rvalid, m0_ready};
  assign bus.m1_resp_o = {s_rdata, m1_rvalid, m1_ready};
  assign state_dbg     = state;
endmodule

// File: tb/tb_iob_soc_opencryptolinux_mem_arb.sv
module tb_iob_soc_opencryptolinux_mem_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RDW  = 2'd2;

  localparam logic [31:0] M0_WDATA = 32'h600DCAFE;
  localparam logic [31:0] M1_WDATA = 32'hDEADBEEF;
  localparam logic [3:0]  F = 4'hF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic cke = 1'b1;
  logic rst = 1'b1;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  iob_soc_opencryptolinux_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iob_soc_opencryptolinux_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i     (clk),
    .cke_i     (cke),
    .rst_i     (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, cke;
    logic        m0_av; logic [31:0] m0_addr; logic [3:0] m0_st;
    logic        m1_av; logic [31:0] m1_addr; logic [3:0] m1_st;
    logic        s_rdy, s_rv; logic [31:0] s_rd;
    logic [1:0]  sel;   // 0 none, 1 m0 forwarded, 2 m1 forwarded
    logic        m0r, m1r, m0v, m1v;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [REQ_W-1:0] mk_req(input logic av, input logic [31:0] addr,
                                              input logic [31:0] wd, input logic [3:0] st);
    return {av, addr, wd, st};
  endfunction

  function automatic vec_t v(input logic r, input logic c,
                             input logic a0, input logic [31:0] ad0, input logic [3:0] st0,
                             input logic a1, input logic [31:0] ad1, input logic [3:0] st1,
                             input logic rdy, input logic rv, input logic [31:0] rd,
                             input logic [1:0] sel, input logic m0r, input logic m1r,
                             input logic m0v, input logic m1v, input logic [1:0] st);
    vec_t x;
    x.rst = r; x.cke = c;
    x.m0_av = a0; x.m0_addr = ad0; x.m0_st = st0;
    x.m1_av = a1; x.m1_addr = ad1; x.m1_st = st1;
    x.s_rdy = rdy; x.s_rv = rv; x.s_rd = rd;
    x.sel = sel; x.m0r = m0r; x.m1r = m1r; x.m0v = m0v; x.m1v = m1v; x.st = st;
    return x;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_vec(input vec_t x);
    rst = x.rst;
    cke = x.cke;
    bus.m0_req_i = mk_req(x.m0_av, x.m0_addr, M0_WDATA, x.m0_st);
    bus.m1_req_i = mk_req(x.m1_av, x.m1_addr, M1_WDATA, x.m1_st);
    bus.s_resp_i = {x.s_rd, x.s_rv, x.s_rdy};
  endtask

  task automatic check_vec(input int idx, input vec_t x);
    logic [REQ_W-1:0] exp_req;
    string tag;
    tag = $sformatf("vec%0d", idx);
    case (x.sel)
      2'd1:    exp_req = mk_req(x.m0_av, x.m0_addr, M0_WDATA, x.m0_st);
      2'd2:    exp_req = mk_req(x.m1_av, x.m1_addr, M1_WDATA, x.m1_st);
      default: exp_req = '0;
    endcase
    check({tag, " s_req"}, 128'(bus.s_req_o), 128'(exp_req));
    check({tag, " m0_resp"}, 128'(bus.m0_resp_o), 128'({x.s_rd, x.m0v, x.m0r}));
    check({tag, " m1_resp"}, 128'(bus.m1_resp_o), 128'({x.s_rd, x.m1v, x.m1r}));
    check({tag, " state"}, 128'(state_dbg), 128'(x.st));
  endtask

  // ---------------- scoreboard for contention ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];

  initial begin
    int idx0, idx1, cyc;
    logic [31:0] e, g;

    bus.m0_req_i = '0;
    bus.m1_req_i = '0;
    bus.s_resp_i = '0;

    // reset with both masters requesting, then first tie to m0
    vecs.push_back(v(1,1, 1,'h10,F, 1,'h20,F, 0,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(1,1, 1,'h10,F, 1,'h20,F, 0,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 1,'h10,F, 1,'h20,F, 0,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 1,'h10,F, 1,'h20,F, 1,0,0, 1,1,0,0,0,S_BUSY));
    // single m1 write, then the next tie must go to m0
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 1,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 1,0,0, 2,0,1,0,0,S_BUSY));
    vecs.push_back(v(0,1, 1,'h10,F, 1,'h100,F, 0,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 1,'h10,F, 1,'h100,F, 0,0,0, 1,0,0,0,0,S_BUSY));
    // m0 withdraws before acceptance: grant released, prio kept at 0
    vecs.push_back(v(0,1, 0,'h10,F, 1,'h100,F, 1,0,0, 1,1,0,0,0,S_BUSY));
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 0,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 1,0,0, 2,0,1,0,0,S_BUSY));
    // read routing: m0 reads 0x40, rvalid at cycle 4, m1 waits from cycle 2
    vecs.push_back(v(0,1, 1,'h40,0, 0,0,0, 1,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 1,'h40,0, 0,0,0, 1,0,0, 1,1,0,0,0,S_BUSY));
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 1,0,0, 0,0,0,0,0,S_RDW));
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 1,0,'hAAAA5555, 0,0,0,0,0,S_RDW));
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 1,1,'h12345678, 0,0,0,1,0,S_RDW));
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 1,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 1,0,0, 2,0,1,0,0,S_BUSY));
    // stray rvalid in IDLE and in BUSY is dropped
    vecs.push_back(v(0,1, 0,0,0, 0,0,0, 0,1,'h0BADF00D, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 1,'h44,0, 0,0,0, 0,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 1,'h44,0, 0,0,0, 0,1,'h0BADF00D, 1,0,0,0,0,S_BUSY));
    vecs.push_back(v(0,1, 1,'h44,0, 0,0,0, 1,0,0, 1,1,0,0,0,S_BUSY));
    vecs.push_back(v(0,1, 0,0,0, 0,0,0, 0,1,'h55AA55AA, 0,0,0,1,0,S_RDW));
    // abort: reset during m1 RD_WAIT, late rvalid dropped, m0 read follows
    vecs.push_back(v(0,1, 0,0,0, 1,'h80,0, 0,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 0,0,0, 1,'h80,0, 1,0,0, 2,0,1,0,0,S_BUSY));
    vecs.push_back(v(0,1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,S_RDW));
    vecs.push_back(v(1,1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,S_RDW));
    vecs.push_back(v(0,1, 0,0,0, 0,0,0, 0,1,'h77778888, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 1,'h48,0, 0,0,0, 0,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 1,'h48,0, 0,0,0, 1,0,0, 1,1,0,0,0,S_BUSY));
    vecs.push_back(v(0,1, 0,0,0, 0,0,0, 0,1,'hCAFEF00D, 0,0,0,1,0,S_RDW));
    // clock enable low in m1 RD_WAIT with rvalid held
    vecs.push_back(v(0,1, 0,0,0, 1,'h84,0, 0,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 0,0,0, 1,'h84,0, 1,0,0, 2,0,1,0,0,S_BUSY));
    vecs.push_back(v(0,0, 0,0,0, 0,0,0, 0,1,'h11112222, 0,0,0,0,1,S_RDW));
    vecs.push_back(v(0,0, 0,0,0, 0,0,0, 0,1,'h11112222, 0,0,0,0,1,S_RDW));
    vecs.push_back(v(0,0, 0,0,0, 0,0,0, 0,1,'h11112222, 0,0,0,0,1,S_RDW));
    vecs.push_back(v(0,1, 0,0,0, 0,0,0, 0,1,'h11112222, 0,0,0,0,1,S_RDW));
    vecs.push_back(v(0,1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,S_IDLE));
    // clock enable low in IDLE holds off the grant
    vecs.push_back(v(0,0, 0,0,0, 1,'h100,F, 1,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 1,0,0, 0,0,0,0,0,S_IDLE));
    vecs.push_back(v(0,1, 0,0,0, 1,'h100,F, 1,0,0, 2,0,1,0,0,S_BUSY));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // ---------------- contention: 4 writes per master, zero-wait slave ----
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h1000 + 32'(4 * i));
      exp_q.push_back(32'h2000 + 32'(4 * i));
    end
    idx0 = 0;
    idx1 = 0;
    cyc  = 0;
    rst  = 1'b0;
    cke  = 1'b1;
    while (got_q.size() < 8 && cyc < 40) begin
      @(negedge clk);
      bus.m0_req_i = (idx0 < 4) ? mk_req(1'b1, 32'h1000 + 32'(4 * idx0), M0_WDATA, F) : '0;
      bus.m1_req_i = (idx1 < 4) ? mk_req(1'b1, 32'h2000 + 32'(4 * idx1), M1_WDATA, F) : '0;
      bus.s_resp_i = {32'h0, 1'b0, 1'b1};
      #1;
      if (bus.s_req_o[REQ_W-1] && bus.s_resp_i[0]) begin
        got_q.push_back(bus.s_req_o[REQ_W-2 -: ADDR_W]);
        got_cyc.push_back(cyc);
      end
      if (bus.m0_resp_o[0] && bus.m0_req_i[REQ_W-1]) idx0++;
      if (bus.m1_resp_o[0] && bus.m1_req_i[REQ_W-1]) idx1++;
      cyc++;
    end
    check("contention transfer count", 128'(got_q.size()), 128'(8));
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hFFFFFFFF;
      check($sformatf("contention order %0d", i), 128'(g), 128'(e));
    end
    for (int i = 1; i < got_cyc.size(); i++)
      check($sformatf("contention spacing %0d", i), 128'(got_cyc[i] - got_cyc[i-1]), 128'(2));

    @(negedge clk);
    bus.m0_req_i = '0;
    bus.m1_req_i = '0;
    bus.s_resp_i = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
